// File: rtl/lab_pkg.sv
// Shared types and constants for the LAB digitize controller and its queue.
package lab_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP,
      ST_ADDR,
      ST_CAPT,
      ST_FIN
   } lab_state_e;

   localparam int NBUF   = 4;
   localparam int BUF_W  = 2;
   localparam int RAM_AW = 13;
   localparam int RAM_DW = 16;
   localparam int WORD_W = RAM_AW - BUF_W;

   // RAM data word: channel number in the top nibble, ADC sample below it
   localparam int WDAT_CHAN_W = 4;
   localparam int WDAT_DAT_W  = 12;

   function automatic logic [RAM_DW-1:0] pack_wdat(input logic [WDAT_CHAN_W-1:0] chan,
                                                   input logic [WDAT_DAT_W-1:0]  dat);
      return {chan, dat};
   endfunction

endpackage

// File: rtl/lab_req_queue.sv
// Per-buffer pending/ready bookkeeping, sticky error and lowest-index arbiter.
module lab_req_queue
   import lab_pkg::*;
(
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic             clr_i,
   input  logic [NBUF-1:0]  digitize_i,
   input  logic             done_i,
   input  logic [BUF_W-1:0] done_buf_i,
   input  logic             take_i,
   input  logic             fin_i,
   input  logic             busy_i,
   input  logic [BUF_W-1:0] active_i,
   output logic             pick_vld_o,
   output logic [BUF_W-1:0] pick_idx_o,
   output logic [NBUF-1:0]  ready_o,
   output logic             err_o
);

   logic [NBUF-1:0] pending_q, pending_d;
   logic [NBUF-1:0] ready_q, ready_d;
   logic            err_q, err_d;
   logic [NBUF-1:0] rdy_rel;

   // Release first, then accept strobes against the released view; arbitrate lowest pending
   always_comb begin
      rdy_rel = ready_q;
      if (done_i) rdy_rel[done_buf_i] = 1'b0;

      pick_vld_o = |pending_q;
      pick_idx_o = '0;
      for (int n = NBUF-1; n >= 0; n--)
         if (pending_q[n]) pick_idx_o = BUF_W'(n);

      pending_d = pending_q;
      if (take_i && pick_vld_o) pending_d[pick_idx_o] = 1'b0;

      err_d = err_q;
      for (int n = 0; n < NBUF; n++) begin
         if (digitize_i[n]) begin
            if (pending_q[n] || (busy_i && active_i == BUF_W'(n)) || rdy_rel[n])
               err_d = 1'b1;
            else
               pending_d[n] = 1'b1;
         end
      end

      ready_d = rdy_rel;
      if (fin_i) ready_d[active_i] = 1'b1;

      if (clr_i) begin
         pending_d = '0;
         ready_d   = '0;
         err_d     = 1'b0;
      end
   end

   // Bookkeeping registers
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         pending_q <= '0;
         ready_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   assign ready_o = ready_q;
   assign err_o   = err_q;

endmodule

// File: rtl/lab_digitize_ctrl.sv
// Wilkinson ramp + channel/sample readout sequencer writing the LAB RAM.
module lab_digitize_ctrl
   import lab_pkg::*;
#(
   parameter int NSAMP         = 256,
   parameter int NCHAN         = 8,
   parameter int RAMP_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 2,
   parameter int DAT_W         = 12
) (
   input  logic                     clk_i,
   input  logic                     nrst_i,
   input  logic                     clr_i,
   input  logic [NBUF-1:0]          digitize_i,
   input  logic                     done_i,
   input  logic [BUF_W-1:0]         done_buf_i,
   input  logic [BUF_W-1:0]         rd_buf_i,
   input  logic [DAT_W-1:0]         lab_dat_i,
   output logic                     ramp_o,
   output logic                     wclk_en_o,
   output logic [$clog2(NCHAN)-1:0] chan_o,
   output logic [$clog2(NSAMP)-1:0] smp_o,
   output logic                     ram_we_o,
   output logic [RAM_AW-1:0]        ram_waddr_o,
   output logic [RAM_DW-1:0]        ram_wdat_o,
   output logic [NBUF-1:0]          ready_o,
   output logic                     lab_ready_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int CW    = $clog2(NCHAN);
   localparam int SW    = $clog2(NSAMP);
   localparam int WW    = CW + SW;
   localparam int CMAX  = (RAMP_CYCLES > SETTLE_CYCLES) ? RAMP_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W = $clog2(CMAX + 1);

   lab_state_e        state_q, state_d;
   logic [BUF_W-1:0]  active_q, active_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WW-1:0]     word_q, word_d;
   logic              ramp_q, we_q;
   logic [RAM_AW-1:0] waddr_q, waddr_d;
   logic [RAM_DW-1:0] wdat_q, wdat_d;

   logic              pick_vld;
   logic [BUF_W-1:0]  pick_idx;

   lab_req_queue u_queue (
      .clk_i      (clk_i),
      .nrst_i     (nrst_i),
      .clr_i      (clr_i),
      .digitize_i (digitize_i),
      .done_i     (done_i),
      .done_buf_i (done_buf_i),
      .take_i     (state_q == ST_IDLE),
      .fin_i      (state_q == ST_FIN),
      .busy_i     (state_q != ST_IDLE),
      .active_i   (active_q),
      .pick_vld_o (pick_vld),
      .pick_idx_o (pick_idx),
      .ready_o    (ready_o),
      .err_o      (err_o)
   );

   // Next state, counters, and the registered-output values for the coming cycle
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      unique case (state_q)
         ST_IDLE: if (pick_vld) begin
            active_d = pick_idx;
            cnt_d    = '0;
            word_d   = '0;
            state_d  = ST_RAMP;
         end
         ST_RAMP: if (cnt_q == CNT_W'(RAMP_CYCLES-1)) begin
            cnt_d   = '0;
            state_d = ST_ADDR;
         end else cnt_d = cnt_q + 1'b1;
         ST_ADDR: if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
            cnt_d   = '0;
            state_d = ST_CAPT;
         end else cnt_d = cnt_q + 1'b1;
         ST_CAPT: begin
            // word counter wraps to 0 after the last sample of the last channel
            word_d  = word_q + 1'b1;
            state_d = (&word_q) ? ST_FIN : ST_ADDR;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (clr_i) begin
         state_d  = ST_IDLE;
         active_d = '0;
         cnt_d    = '0;
         word_d   = '0;
      end

      waddr_d = '0;
      wdat_d  = '0;
      if (state_d == ST_CAPT) begin
         waddr_d = {active_d, WORD_W'(word_d)};
         wdat_d  = pack_wdat(WDAT_CHAN_W'(word_d[WW-1:SW]), WDAT_DAT_W'(lab_dat_i));
      end
   end

   // State and glitch-free registered outputs
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q  <= ST_IDLE;
         active_q <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         ramp_q   <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         ramp_q   <= (state_d == ST_RAMP);
         we_q     <= (state_d == ST_CAPT);
         waddr_q  <= waddr_d;
         wdat_q   <= wdat_d;
      end
   end

   assign ramp_o      = ramp_q;
   assign wclk_en_o   = ramp_q;
   assign ram_we_o    = we_q;
   assign ram_waddr_o = waddr_q;
   assign ram_wdat_o  = wdat_q;
   assign chan_o      = word_q[WW-1:SW];
   assign smp_o       = word_q[SW-1:0];
   assign busy_o      = (state_q != ST_IDLE);
   assign lab_ready_o = ready_o[rd_buf_i];

endmodule

// File: tb/tb_lab_digitize_ctrl.sv
// Randomized + directed bench for lab_digitize_ctrl against a timing-offset reference model.
module tb_lab_digitize_ctrl;

   localparam int NSAMP  = 4;
   localparam int NCHAN  = 2;
   localparam int RAMP   = 8;
   localparam int SETTLE = 1;
   localparam int DAT_W  = 12;
   localparam int NW     = NSAMP * NCHAN;
   localparam int FIN_T  = RAMP + NW * (SETTLE + 1);   // job offset of the FIN cycle

   logic             clk_i = 1'b0;
   logic             nrst_i, clr_i, done_i;
   logic [3:0]       digitize_i;
   logic [1:0]       done_buf_i, rd_buf_i;
   logic [DAT_W-1:0] lab_dat_i;
   logic             ramp_o, wclk_en_o, ram_we_o, lab_ready_o, busy_o, err_o;
   logic [0:0]       chan_o;
   logic [1:0]       smp_o;
   logic [12:0]      ram_waddr_o;
   logic [15:0]      ram_wdat_o;
   logic [3:0]       ready_o;

   always #5 clk_i = ~clk_i;

   lab_digitize_ctrl #(
      .NSAMP(NSAMP), .NCHAN(NCHAN), .RAMP_CYCLES(RAMP), .SETTLE_CYCLES(SETTLE), .DAT_W(DAT_W)
   ) dut (
      .clk_i(clk_i), .nrst_i(nrst_i), .clr_i(clr_i), .digitize_i(digitize_i),
      .done_i(done_i), .done_buf_i(done_buf_i), .rd_buf_i(rd_buf_i), .lab_dat_i(lab_dat_i),
      .ramp_o(ramp_o), .wclk_en_o(wclk_en_o), .chan_o(chan_o), .smp_o(smp_o),
      .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdat_o(ram_wdat_o),
      .ready_o(ready_o), .lab_ready_o(lab_ready_o), .busy_o(busy_o), .err_o(err_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: masks plus one job described by its cycle offset m_t
   logic [3:0]  m_pend, m_rdy;
   logic        m_err, m_busy;
   int          m_act, m_t;
   logic [11:0] m_dat;

   task automatic model_reset;
      m_pend = '0; m_rdy = '0; m_err = 1'b0; m_busy = 1'b0; m_act = 0; m_t = 0; m_dat = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step;
      logic [3:0] rel, acc;
      if (!nrst_i || clr_i) begin
         model_reset;
         return;
      end
      rel = m_rdy;
      if (done_i) rel[done_buf_i] = 1'b0;
      acc = '0;
      for (int n = 0; n < 4; n++)
         if (digitize_i[n]) begin
            if (!m_pend[n] && !(m_busy && m_act == n) && !rel[n]) acc[n] = 1'b1;
            else m_err = 1'b1;
         end
      m_rdy = rel;
      if (m_busy) begin
         if (m_t == FIN_T) begin
            m_rdy[m_act] = 1'b1;
            m_busy = 1'b0;
         end else m_t++;
      end else if (m_pend != 0) begin
         for (int k = 3; k >= 0; k--) if (m_pend[k]) m_act = k;
         m_pend[m_act] = 1'b0;
         m_busy = 1'b1;
         m_t = 0;
      end
      m_pend |= acc;
      if (m_busy && m_t >= RAMP && m_t < FIN_T && (m_t - RAMP) % (SETTLE + 1) == SETTLE)
         m_dat = lab_dat_i;
   endtask

   task automatic check_outputs;
      int w, word, ch, sm, addr, wd;
      logic rmp, we;
      rmp = 0; we = 0; ch = 0; sm = 0; addr = 0; wd = 0;
      if (m_busy) begin
         if (m_t < RAMP) rmp = 1'b1;
         else if (m_t < FIN_T) begin
            w    = m_t - RAMP;
            word = w / (SETTLE + 1);
            ch   = word / NSAMP;
            sm   = word % NSAMP;
            we   = (w % (SETTLE + 1)) == SETTLE;
            if (we) begin
               addr = m_act * 2048 + word;
               wd   = ch * 4096 + int'(m_dat);
            end
         end
      end
      chk("ramp_o", ramp_o, rmp);
      chk("wclk_en_o", wclk_en_o, rmp);
      chk("chan_o", chan_o, ch);
      chk("smp_o", smp_o, sm);
      chk("ram_we_o", ram_we_o, we);
      chk("ram_waddr_o", ram_waddr_o, addr);
      chk("ram_wdat_o", ram_wdat_o, wd);
      chk("ready_o", ready_o, m_rdy);
      chk("lab_ready_o", lab_ready_o, m_rdy[rd_buf_i]);
      chk("busy_o", busy_o, m_busy);
      chk("err_o", err_o, m_err);
   endtask

   // One clock: model, edge, check, then drop strobes and randomize free inputs
   task automatic cyc;
      model_step;
      @(posedge clk_i);
      #1;
      check_outputs;
      digitize_i = '0; done_i = 1'b0; clr_i = 1'b0;
      lab_dat_i  = DAT_W'($urandom);
      rd_buf_i   = 2'($urandom);
   endtask

   initial begin
      int first_ramp, first_rdy, nwe, nramp;
      nrst_i = 1'b0; clr_i = 1'b0; done_i = 1'b0; digitize_i = '0;
      done_buf_i = '0; rd_buf_i = '0; lab_dat_i = 12'h5a5;
      model_reset;
      cyc; cyc;
      chk("rst_ready", ready_o, 0);
      chk("rst_busy", busy_o, 0);
      nrst_i = 1'b1;

      // single buffer: latency and address pattern
      digitize_i = 4'b0100;
      first_ramp = -1; first_rdy = -1; nwe = 0; nramp = 0;
      for (int k = 1; k <= 30; k++) begin
         cyc;
         if (ramp_o) nramp++;
         if (ramp_o && first_ramp < 0) first_ramp = k;
         if (ready_o[2] && first_rdy < 0) first_rdy = k;
         if (ram_we_o) begin
            chk("t1_addr", ram_waddr_o, 32'h1000 + nwe);
            chk("t1_chan", ram_wdat_o[15:12], nwe / NSAMP);
            nwe++;
         end
      end
      chk("t1_ramp_rise", first_ramp, 2);
      chk("t1_ramp_len", nramp, RAMP);
      chk("t1_ready_rise", first_rdy, 3 + RAMP + NW * (SETTLE + 1));
      chk("t1_we_count", nwe, NW);
      chk("t1_ready", ready_o, 4'b0100);

      // two strobes in one cycle: lowest index first
      done_i = 1'b1; done_buf_i = 2'd2; digitize_i = 4'b1001;
      cyc;
      for (int i = 0; i < 100 && ready_o == 0; i++) cyc;
      chk("t2_first_ready", ready_o, 4'b0001);
      for (int i = 0; i < 100 && ready_o != 4'b1001; i++) cyc;
      chk("t2_both_ready", ready_o, 4'b1001);
      chk("t2_err", err_o, 0);

      // digitize on a ready buffer is an error; release then accept
      digitize_i = 4'b0001;
      cyc;
      chk("t3_err", err_o, 1);
      repeat (4) cyc;
      chk("t3_no_ramp", busy_o, 0);
      done_i = 1'b1; done_buf_i = 2'd0;
      cyc;
      chk("t3_released", ready_o[0], 0);
      digitize_i = 4'b0001;
      cyc; cyc;
      chk("t3_accept_ramp", ramp_o, 1);
      for (int i = 0; i < 100 && !ready_o[0]; i++) cyc;
      chk("t3_done", ready_o[0], 1);

      // release and re-digitize same buffer in the same cycle
      clr_i = 1'b1;
      cyc;
      chk("t4_clr_err", err_o, 0);
      digitize_i = 4'b0010;
      cyc;
      for (int i = 0; i < 100 && !ready_o[1]; i++) cyc;
      chk("t4_ready1", ready_o[1], 1);
      done_i = 1'b1; done_buf_i = 2'd1; digitize_i = 4'b0010;
      cyc;
      chk("t4_ready_clr", ready_o[1], 0);
      chk("t4_no_err", err_o, 0);
      cyc;
      chk("t4_ramp", ramp_o, 1);

      // clear during capture with another buffer queued
      digitize_i = 4'b0001;
      cyc;
      for (int i = 0; i < 100 && !ram_we_o; i++) cyc;
      chk("t5_reach_capt", ram_we_o, 1);
      clr_i = 1'b1;
      cyc;
      chk("t5_we", ram_we_o, 0);
      chk("t5_busy", busy_o, 0);
      chk("t5_ready", ready_o, 0);
      repeat (5) cyc;
      chk("t5_queue_empty", busy_o, 0);

      // asynchronous reset in the middle of the ramp
      digitize_i = 4'b0100;
      cyc; cyc; cyc;
      chk("t6_in_ramp", ramp_o, 1);
      #2 nrst_i = 1'b0;
      #1;
      model_reset;
      chk("t6_ramp_async", ramp_o, 0);
      chk("t6_wclk_async", wclk_en_o, 0);
      check_outputs;
      cyc;
      nrst_i = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) digitize_i = 4'($urandom);
         if ($urandom_range(5) == 0) begin
            done_i = 1'b1;
            done_buf_i = 2'($urandom);
         end
         if ($urandom_range(399) == 0) clr_i = 1'b1;
         cyc;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
